// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: scheduler state encoding, default widths and index-width helper
package alu_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int N_DEF       = 4;
  localparam int DATA_W_DEF  = 5;
  localparam int RES_W_DEF   = 6;
  localparam int AOP_W_DEF   = 3;
  localparam int BOP_W_DEF   = 2;
  localparam int ALU_LAT_DEF = 1;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/alu_sched_arb.sv
// alu_sched_arb: N-way arbiter, round-robin by default, lowest-index-wins when ALU_SCHED_FIXED_PRIO_EN is defined
module alu_sched_arb
  import alu_sched_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          take,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);
`ifdef ALU_SCHED_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst, take};
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[k]) begin
        win = '0;
        win[k] = 1'b1;
        win_idx = IW'(k);
      end
  end
`else
  logic [IW-1:0] ptr;
  // scan offsets from highest down so the smallest offset from ptr wins
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        win = '0;
        win[(int'(ptr) + k) % N] = 1'b1;
        win_idx = IW'((int'(ptr) + k) % N);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (take) ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
`endif
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU among N requesters; ALU_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int AOP_W   = AOP_W_DEF,
  parameter int BOP_W   = BOP_W_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       req_a_en,
  input  logic [N-1:0]       req_b_en,
  input  logic [N*AOP_W-1:0] req_a_op,
  input  logic [N*BOP_W-1:0] req_b_op,
  input  logic [N*DATA_W-1:0] req_A,
  input  logic [N*DATA_W-1:0] req_B,
  output logic [N-1:0]       gnt,
  output logic               ALU_en,
  output logic               a_en,
  output logic               b_en,
  output logic [AOP_W-1:0]   a_op,
  output logic [BOP_W-1:0]   b_op,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  input  logic [RES_W-1:0]   C,
  output logic               resp_valid,
  output logic [IW-1:0]      resp_id,
  output logic [RES_W-1:0]   resp_data,
  output logic               busy
);
  localparam int CW = idx_w(ALU_LAT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0] win, gnt_q;
  logic [IW-1:0] win_idx;
  logic take;
  assign take = (state == IDLE) && |req;
  alu_sched_arb #(.N(N)) u_arb (
    .clk(clk), .rst(rst), .req(req), .take(take), .win(win), .win_idx(win_idx)
  );
  always_comb begin
    state_nx = (state == IDLE)  ? (take ? ISSUE : IDLE) :
               (state == ISSUE) ? WAIT :
               (state == WAIT)  ? ((cnt == CW'(1)) ? RESP : WAIT) : IDLE;
  end
  assign gnt        = (state == ISSUE) ? gnt_q : '0;
  assign ALU_en     = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  // ALU-facing fields are the latched winner's; they hold through WAIT and beyond
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_q     <= '0;
      resp_id   <= '0;
      a_en      <= 1'b0;
      b_en      <= 1'b0;
      a_op      <= '0;
      b_op      <= '0;
      A         <= '0;
      B         <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        gnt_q   <= win;
        resp_id <= win_idx;
        a_en    <= req_a_en[win_idx];
        b_en    <= req_b_en[win_idx];
        a_op    <= req_a_op[win_idx*AOP_W +: AOP_W];
        b_op    <= req_b_op[win_idx*BOP_W +: BOP_W];
        A       <= req_A[win_idx*DATA_W +: DATA_W];
        B       <= req_B[win_idx*DATA_W +: DATA_W];
      end
      if (state == ISSUE) cnt <= CW'(ALU_LAT);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == CW'(1)) resp_data <= C;
    end
endmodule
